warp_sequencer: RTL and testbench

Sequences the lightspeed streak generator through a full jump: idle, speed ramp-up, sustained warp, speed ramp-down. It sits between the frame-strobe source and the lightspeed block. It drives that block's animate enable, reset and a rate-divided animation strobe. Game control triggers it with one pulse and may abort a jump in progress; the pause state freezes the sequence.

---
 rtl/warp_pkg.sv | 15 +
 rtl/warp_sequencer_strobe_div.sv | 40 ++++
 rtl/warp_sequencer.sv | 154 +++++++++++++++
 tb/tb_warp_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_pkg.sv
// Shared types and widths for the warp jump sequencer.
package warp_pkg;

  localparam int DIV_W  = 4;
  localparam int STEP_W = 8;
  localparam int WARP_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    WARP   = 2'd2,
    COOL   = 2'd3
  } state_t;

endpackage

// File: rtl/warp_sequencer_strobe_div.sv
// Rate divider: passes every div-th counted frame as a one-cycle strobe.
module strobe_div
  import warp_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             cf_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_changed_i,
  output logic             stb_o
);

  logic [DIV_W-1:0] pc_q, pc_d;
  logic             stb_q, stb_d;

  // The pulse decision uses the phase before any restart, so a frame that
  // changes the divider still emits its own strobe.
  always_comb begin
    pc_d  = pc_q;
    stb_d = cf_i && (pc_q == '0);
    if (div_changed_i) begin
      pc_d = '0;
    end else if (cf_i) begin
      pc_d = (pc_q == div_i - 4'd1) ? '0 : pc_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q  <= '0;
      stb_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      stb_q <= stb_d;
    end
  end

  assign stb_o = stb_q;

endmodule

// File: rtl/warp_sequencer.sv
// Jump sequencer for the lightspeed streaks: idle, ramp-up, warp, ramp-down.
module warp_sequencer
  import warp_pkg::*;
#(
  parameter int MAX_DIV     = 4,
  parameter int RAMP_STEP   = 16,
  parameter int WARP_FRAMES = 240
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ani_stb,
  input  logic       i_paused,
  input  logic       i_trigger,
  input  logic       i_abort,
  output logic       o_ani_stb,
  output logic       o_animate,
  output logic       o_light_rst,
  output logic [1:0] o_state,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [DIV_W-1:0]  MAX_DIV_C = DIV_W'(MAX_DIV);
  localparam logic [STEP_W-1:0] RAMP_LAST = STEP_W'(RAMP_STEP - 1);
  localparam logic [WARP_W-1:0] WARP_LAST = WARP_W'(WARP_FRAMES - 1);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [STEP_W-1:0] sc_q, sc_d;
  logic [WARP_W-1:0] wc_q, wc_d;
  logic              busy_q, busy_d;
  logic              animate_q, animate_d;
  logic              light_rst_q, light_rst_d;
  logic              done_q, done_d;
  logic              start_jump, end_jump;
  logic              cf, div_changed;

  assign cf = i_ani_stb & ~i_paused;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      div_q       <= MAX_DIV_C;
      sc_q        <= '0;
      wc_q        <= '0;
      busy_q      <= 1'b0;
      animate_q   <= 1'b0;
      light_rst_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sc_q        <= sc_d;
      wc_q        <= wc_d;
      busy_q      <= busy_d;
      animate_q   <= animate_d;
      light_rst_q <= light_rst_d;
      done_q      <= done_d;
    end
  end

  // Abort is tested ahead of the frame handling so it beats a concurrent
  // frame-driven transition.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sc_d       = sc_q;
    wc_d       = wc_q;
    start_jump = 1'b0;
    end_jump   = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_d = MAX_DIV_C;
        if (i_trigger && !i_paused) begin
          state_d    = CHARGE;
          sc_d       = '0;
          start_jump = 1'b1;
        end
      end
      CHARGE: begin
        if (i_abort) begin
          state_d = COOL;
          sc_d    = '0;
        end else if (cf) begin
          if (sc_q == RAMP_LAST) begin
            sc_d  = '0;
            div_d = div_q - 4'd1;
            if (div_q == 4'd2) begin
              state_d = WARP;
              wc_d    = '0;
            end
          end else begin
            sc_d = sc_q + 8'd1;
          end
        end
      end
      WARP: begin
        if (i_abort) begin
          state_d = COOL;
          sc_d    = '0;
        end else if (cf) begin
          if (wc_q == WARP_LAST) begin
            state_d = COOL;
            sc_d    = '0;
          end else begin
            wc_d = wc_q + 12'd1;
          end
        end
      end
      COOL: begin
        if (cf) begin
          if (sc_q == RAMP_LAST) begin
            sc_d = '0;
            if (div_q < MAX_DIV_C) begin
              div_d = div_q + 4'd1;
            end else begin
              state_d  = IDLE;
              end_jump = 1'b1;
            end
          end else begin
            sc_d = sc_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    light_rst_d = start_jump | end_jump;
    done_d      = end_jump;
    busy_d      = (state_d != IDLE);
    animate_d   = (state_d != IDLE);
  end

  // A new jump restarts the strobe phase just like a divider step does.
  assign div_changed = (div_d != div_q) | start_jump;

  strobe_div u_strobe_div (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .cf_i          (cf && (state_q != IDLE)),
    .div_i         (div_q),
    .div_changed_i (div_changed),
    .stb_o         (o_ani_stb)
  );

  assign o_animate   = animate_q;
  assign o_light_rst = light_rst_q;
  assign o_state     = state_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_warp_sequencer.sv
// Bench for warp_sequencer: per-cycle scoreboard, vector table, jump scenarios.
module tb_warp_sequencer;
  import warp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stb, paused, trig, abort;
  logic a_stb, a_anim, a_lrst, a_busy, a_done;
  logic b_stb, b_anim, b_lrst, b_busy, b_done;
  logic [1:0] a_state, b_state;

  warp_sequencer dut_a (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_paused(paused),
    .i_trigger(trig), .i_abort(abort), .o_ani_stb(a_stb), .o_animate(a_anim),
    .o_light_rst(a_lrst), .o_state(a_state), .o_busy(a_busy), .o_done(a_done)
  );

  warp_sequencer #(.MAX_DIV(4), .RAMP_STEP(1), .WARP_FRAMES(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_paused(paused),
    .i_trigger(trig), .i_abort(abort), .o_ani_stb(b_stb), .o_animate(b_anim),
    .o_light_rst(b_lrst), .o_state(b_state), .o_busy(b_busy), .o_done(b_done)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       stb;
    logic       lrst;
    logic       done;
    logic       busy;
    logic       anim;
  } exp_t;

  exp_t sbq[$];

  // Reference model of dut_a (MAX_DIV=4, RAMP_STEP=16, WARP_FRAMES=240).
  logic [1:0] m_st;
  int m_div, m_sc, m_wc, m_ph;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_predict();
    exp_t e;
    bit cf;
    cf = stb && !paused;
    e = '0;
    if (rst) begin
      m_st = IDLE; m_div = 4; m_sc = 0; m_wc = 0; m_ph = 0;
    end else begin
      if (cf && m_st != IDLE) begin
        e.stb = ((m_ph % m_div) == 0);
        m_ph++;
      end
      case (m_st)
        IDLE: if (trig && !paused) begin
          m_st = CHARGE; m_sc = 0; m_ph = 0; e.lrst = 1'b1;
        end
        CHARGE: if (abort) begin
          m_st = COOL; m_sc = 0;
        end else if (cf) begin
          if (m_sc == 15) begin
            m_sc = 0; m_div--; m_ph = 0;
            if (m_div == 1) begin m_st = WARP; m_wc = 0; end
          end else m_sc++;
        end
        WARP: if (abort) begin
          m_st = COOL; m_sc = 0;
        end else if (cf) begin
          if (m_wc == 239) begin m_st = COOL; m_sc = 0; end
          else m_wc++;
        end
        default: if (cf) begin
          if (m_sc == 15) begin
            m_sc = 0;
            if (m_div < 4) begin m_div++; m_ph = 0; end
            else begin m_st = IDLE; e.done = 1'b1; e.lrst = 1'b1; end
          end else m_sc++;
        end
      endcase
    end
    e.st   = m_st;
    e.busy = (m_st != IDLE);
    e.anim = (m_st != IDLE);
    sbq.push_back(e);
  endtask

  // One clock: predict from the driven inputs, clock, then compare dut_a.
  task automatic tick();
    exp_t e, act;
    model_predict();
    @(posedge clk);
    #1;
    act = '{a_state, a_stb, a_lrst, a_done, a_busy, a_anim};
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty actual=%h expected=none", act);
    end else begin
      e = sbq.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL cycle t=%0t actual={st,stb,lrst,done,busy,anim}=%b required=%b",
                 $time, act, e);
      end
    end
  endtask

  bit sel;
  int r_cf[4], r_pul[4], r_done, r_lrst;

  function automatic logic [1:0] cur_st();
    return sel ? b_state : a_state;
  endfunction

  // Triggers a jump and runs until the selected DUT returns to IDLE,
  // counting frames and strobes per state the frame was applied in.
  task automatic run_jump(input string name, input bit use_b, input int period,
                          input int abort_k, input int pause_k, input int pause_len,
                          input bit trig_noise);
    int k, pf;
    bit aborted, finished, cf;
    logic [1:0] s;
    sel = use_b;
    for (int i = 0; i < 4; i++) begin r_cf[i] = 0; r_pul[i] = 0; end
    r_done = 0; r_lrst = 0;
    rst = 0; stb = 0; paused = 0; abort = 0; trig = 1;
    tick();
    r_lrst += int'(sel ? b_lrst : a_lrst);
    trig = 0;
    k = 0; pf = 0; aborted = 0; finished = 0;
    for (int c = 0; c < 4000; c++) begin
      s = cur_st();
      if (s == IDLE) begin finished = 1; break; end
      stb    = ((c % period) == 0);
      paused = (pause_k >= 0 && k == pause_k && pf < pause_len);
      if (paused && stb) pf++;
      abort = (abort_k >= 0 && !aborted && k == abort_k);
      if (abort) aborted = 1;
      trig = trig_noise && ((c % 7) == 3);
      cf = stb && !paused;
      if (cf) begin r_cf[s]++; k++; end
      tick();
      if (sel ? b_stb : a_stb) r_pul[s]++;
      r_done += int'(sel ? b_done : a_done);
      r_lrst += int'(sel ? b_lrst : a_lrst);
    end
    stb = 0; paused = 0; abort = 0; trig = 0;
    check({name, "_terminates"}, int'(finished), 1);
  endtask

  typedef struct {
    string      name;
    bit         rst, trig, abort, stb, paused;
    logic [1:0] st;
    bit         lrst;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{"reset",          1, 0, 0, 0, 0, IDLE,   0};
    vt[1] = '{"trig_paused",    0, 1, 0, 1, 1, IDLE,   0};
    vt[2] = '{"abort_idle",     0, 0, 1, 0, 0, IDLE,   0};
    vt[3] = '{"trig_and_abort", 0, 1, 1, 0, 0, CHARGE, 1};
    vt[4] = '{"trig_in_charge", 0, 1, 0, 1, 0, CHARGE, 0};
    vt[5] = '{"abort_charge",   0, 0, 1, 0, 0, COOL,   0};
    vt[6] = '{"trig_in_cool",   0, 1, 0, 0, 0, COOL,   0};
    vt[7] = '{"abort_in_cool",  0, 0, 1, 0, 0, COOL,   0};
    vt[8] = '{"reset_again",    1, 1, 0, 1, 0, IDLE,   0};

    rst = 1; stb = 0; paused = 0; trig = 0; abort = 0; sel = 0;
    m_st = IDLE; m_div = 4; m_sc = 0; m_wc = 0; m_ph = 0;
    tick();
    tick();
    check("reset_state", int'(a_state), int'(IDLE));
    check("reset_outputs", int'({a_stb, a_anim, a_lrst, a_busy, a_done}), 0);

    for (int i = 0; i < 9; i++) begin
      rst = vt[i].rst; trig = vt[i].trig; abort = vt[i].abort;
      stb = vt[i].stb; paused = vt[i].paused;
      tick();
      check({vt[i].name, "_state"}, int'(a_state), int'(vt[i].st));
      check({vt[i].name, "_light_rst"}, int'(a_lrst), int'(vt[i].lrst));
      check({vt[i].name, "_busy"}, int'(a_busy), int'(vt[i].st != IDLE));
    end
    rst = 0; trig = 0; abort = 0; stb = 0; paused = 0;
    tick();

    run_jump("full", 0, 2, -1, -1, 0, 0);
    check("full_charge_cf", r_cf[CHARGE], 48);
    check("full_warp_cf", r_cf[WARP], 240);
    check("full_cool_cf", r_cf[COOL], 64);
    check("full_charge_stb", r_pul[CHARGE], 18);
    check("full_warp_stb", r_pul[WARP], 240);
    check("full_cool_stb", r_pul[COOL], 34);
    check("full_done", r_done, 1);
    check("full_light_rst", r_lrst, 2);

    // Reset in the middle of the cool-down ramp.
    trig = 1; tick(); trig = 0; stb = 1;
    for (int c = 0; c < 1000 && a_state != COOL; c++) tick();
    for (int c = 0; c < 5; c++) tick();
    check("pre_reset_cool", int'(a_state), int'(COOL));
    rst = 1;
    tick();
    check("reset_cool_state", int'(a_state), int'(IDLE));
    check("reset_cool_outputs", int'({a_stb, a_anim, a_lrst, a_busy, a_done}), 0);
    rst = 0; stb = 0;
    tick();
    check("reset_cool_no_done", int'({a_lrst, a_done}), 0);

    // Abort in WARP once wc has reached 100 (on a frame-free cycle).
    run_jump("abort_warp", 0, 2, 148, -1, 0, 0);
    check("abort_warp_charge_cf", r_cf[CHARGE], 48);
    check("abort_warp_warp_cf", r_cf[WARP], 100);
    check("abort_warp_cool_cf", r_cf[COOL], 64);
    check("abort_warp_done", r_done, 1);

    // Abort coinciding with the frame that would drop div from 3 to 2.
    run_jump("abort_charge", 0, 1, 31, -1, 0, 0);
    check("abort_charge_charge_cf", r_cf[CHARGE], 32);
    check("abort_charge_warp_cf", r_cf[WARP], 0);
    check("abort_charge_cool_cf", r_cf[COOL], 32);
    check("abort_charge_done", r_done, 1);

    // 50 paused frames mid-WARP, with stray triggers throughout the jump.
    run_jump("pause_warp", 0, 2, -1, 148, 50, 1);
    check("pause_total_cf", r_cf[CHARGE] + r_cf[WARP] + r_cf[COOL], 352);
    check("pause_warp_cf", r_cf[WARP], 240);
    check("pause_warp_stb", r_pul[WARP], 240);
    check("pause_done", r_done, 1);

    run_jump("short", 1, 1, -1, -1, 0, 0);
    check("short_charge_cf", r_cf[CHARGE], 3);
    check("short_warp_cf", r_cf[WARP], 1);
    check("short_cool_cf", r_cf[COOL], 4);
    check("short_done", r_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
